// File: rtl/riscv_multicycle_ctrl.sv
// Moore multicycle sequencer for an RV32I subset on a shared-ALU datapath.
// Optional MCTRL_MEMWAIT_EN adds a MemReady stall on the memory states.
module riscv_multicycle_ctrl #(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
`ifdef MCTRL_MEMWAIT_EN
    input  logic       MemReady,
`endif
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic       InstrDone,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_FUNCT
    } aluop_t;

    state_t state, state_nxt;
    aluop_t aluop;

    logic mem_rdy;
    logic is_mem, is_r, is_i, is_jal, is_beq, is_sw;
    logic pc_upd, branch, mem_wr, ir_wr, reg_wr, done, ill;
    logic [2:0] fn_ctrl;

`ifdef MCTRL_MEMWAIT_EN
    assign mem_rdy = MemReady;
`else
    assign mem_rdy = 1'b1;
`endif

    assign is_sw  = (op == 7'b0100011);
    assign is_mem = (op == 7'b0000011) || is_sw;
    assign is_r   = (op == 7'b0110011);
    assign is_i   = (op == 7'b0010011);
    assign is_jal = (op == 7'b1101111);
    assign is_beq = (op == 7'b1100011);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_FETCH;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_FETCH;
        pc_upd    = 1'b0;
        branch    = 1'b0;
        AdrSrc    = 1'b0;
        mem_wr    = 1'b0;
        ir_wr     = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        aluop     = ALU_ADD;
        reg_wr    = 1'b0;
        done      = 1'b0;
        ill       = 1'b0;
        case (state)
            S_FETCH: begin
                ir_wr     = mem_rdy;
                pc_upd    = mem_rdy;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_nxt = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                unique case (1'b1)
                    is_mem: state_nxt = S_MEMADR;
                    is_r:   state_nxt = S_EXECR;
                    is_i:   state_nxt = S_EXECI;
                    is_jal: state_nxt = S_JAL;
                    is_beq: state_nxt = S_BEQ;
                    default: begin
                        ill       = 1'b1;
                        state_nxt = ILLEGAL_HALT ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                state_nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc    = 1'b1;
                state_nxt = mem_rdy ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_wr    = 1'b1;
                done      = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_wr    = 1'b1;
                done      = mem_rdy;
                state_nxt = mem_rdy ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                ALUSrcA   = 2'b10;
                aluop     = ALU_FUNCT;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                reg_wr = 1'b1;
                done   = 1'b1;
            end
            S_EXECI: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                aluop     = ALU_FUNCT;
                state_nxt = S_ALUWB;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_upd    = 1'b1;
                state_nxt = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                aluop   = ALU_SUB;
                branch  = 1'b1;
                done    = 1'b1;
            end
            S_HALT: begin
                ill       = 1'b1;
                state_nxt = S_HALT;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Only R-type may subtract; addi ignores Instr[30]
    always_comb begin
        case (funct3)
            3'b000:  fn_ctrl = (funct7b5 & op[5]) ? 3'b110 : 3'b010;
            3'b010:  fn_ctrl = 3'b111;
            3'b110:  fn_ctrl = 3'b001;
            3'b111:  fn_ctrl = 3'b000;
            default: fn_ctrl = 3'b010;
        endcase
    end

    always_comb begin
        unique case (aluop)
            ALU_SUB:   ALUControl = 3'b110;
            ALU_FUNCT: ALUControl = fn_ctrl;
            default:   ALUControl = 3'b010;
        endcase
    end

    always_comb begin
        unique case (1'b1)
            is_sw:   ImmSrc = 2'b01;
            is_beq:  ImmSrc = 2'b10;
            is_jal:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign PCWrite   = reset_n & (pc_upd | (branch & Zero));
    assign IRWrite   = reset_n & ir_wr;
    assign RegWrite  = reset_n & reg_wr;
    assign MemWrite  = reset_n & mem_wr;
    assign InstrDone = reset_n & done;
    assign Illegal   = reset_n & ill;
    assign State     = state;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Randomized bench for riscv_multicycle_ctrl: instruction-sequence model
// checks both ILLEGAL_HALT variants every cycle, plus directed literal pins.
module tb_riscv_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] op = 7'b0000011;
    logic [2:0] funct3 = 3'b010;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       mr = 1'b1;

    logic [1:0]      pcw, adr, mw, irw, rw, dn, il;
    logic [1:0][1:0] rs, sa, sb, im;
    logic [1:0][2:0] al;
    logic [1:0][3:0] st;

    int vectors = 0;
    int fails = 0;

    always #5 clk = ~clk;

    riscv_multicycle_ctrl #(.ILLEGAL_HALT(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .Zero(Zero),
`ifdef MCTRL_MEMWAIT_EN
        .MemReady(mr),
`endif
        .PCWrite(pcw[0]), .AdrSrc(adr[0]), .MemWrite(mw[0]),
        .IRWrite(irw[0]), .ResultSrc(rs[0]), .ALUSrcA(sa[0]),
        .ALUSrcB(sb[0]), .ImmSrc(im[0]), .ALUControl(al[0]),
        .RegWrite(rw[0]), .InstrDone(dn[0]), .Illegal(il[0]),
        .State(st[0])
    );

    riscv_multicycle_ctrl #(.ILLEGAL_HALT(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .Zero(Zero),
`ifdef MCTRL_MEMWAIT_EN
        .MemReady(mr),
`endif
        .PCWrite(pcw[1]), .AdrSrc(adr[1]), .MemWrite(mw[1]),
        .IRWrite(irw[1]), .ResultSrc(rs[1]), .ALUSrcA(sa[1]),
        .ALUSrcB(sb[1]), .ImmSrc(im[1]), .ALUControl(al[1]),
        .RegWrite(rw[1]), .InstrDone(dn[1]), .Illegal(il[1]),
        .State(st[1])
    );

    // Model: per instruction, the list of states visited after DECODE
    int  mst [2];
    int  mseq [2][4];
    int  mlen [2];
    int  midx [2];
    bit  halt_p [2] = '{1'b1, 1'b0};

    function automatic bit legal(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1101111 || o == 7'b1100011;
    endfunction

    function automatic logic [2:0] fn(input logic [6:0] o,
                                      input logic [2:0] f3,
                                      input logic f7);
        if (f3 == 3'd0) return (f7 && o == 7'b0110011) ? 3'b110 : 3'b010;
        if (f3 == 3'd2) return 3'b111;
        if (f3 == 3'd6) return 3'b001;
        if (f3 == 3'd7) return 3'b000;
        return 3'b010;
    endfunction

    function automatic logic [21:0] expv(input int s, input logic [6:0] o,
                                         input logic [2:0] f3, input logic f7,
                                         input logic z, input logic r,
                                         output logic [21:0] m);
        logic pw, ad, w, iw, rg, d, ll, alc;
        logic [1:0] xrs, xsa, xsb, xim;
        logic [2:0] xal;
        pw = 0; ad = 0; w = 0; iw = 0; rg = 0; d = 0; ll = 0; alc = 1;
        xrs = 0; xsa = 0; xsb = 0; xal = 3'b010;
        xim = (o == 7'b0100011) ? 2'd1 : (o == 7'b1100011) ? 2'd2 :
              (o == 7'b1101111) ? 2'd3 : 2'd0;
        case (s)
            0:  begin iw = r; pw = r; xsb = 2; xrs = 2; end
            1:  begin xsa = 1; xsb = 1; ll = !legal(o); end
            2:  begin xsa = 2; xsb = 1; end
            3:  begin ad = 1; alc = 0; end
            4:  begin xrs = 1; rg = 1; d = 1; alc = 0; end
            5:  begin ad = 1; w = 1; d = r; alc = 0; end
            6:  begin xsa = 2; xal = fn(o, f3, f7); end
            7:  begin rg = 1; d = 1; alc = 0; end
            8:  begin xsa = 2; xsb = 1; xal = fn(o, f3, f7); end
            9:  begin xsa = 1; xsb = 2; pw = 1; end
            10: begin xsa = 2; xal = 3'b110; pw = z; d = 1; end
            11: begin ll = 1; alc = 0; end
            default: ;
        endcase
        m = '1;
        if (!alc) m[9:7] = 3'b000;
        return {pw, ad, w, iw, xrs, xsa, xsb, xim, xal, rg, d, ll, 4'(s)};
    endfunction

    function automatic logic [21:0] actv(input int k);
        return {pcw[k], adr[k], mw[k], irw[k], rs[k], sa[k], sb[k], im[k],
                al[k], rw[k], dn[k], il[k], st[k]};
    endfunction

    initial begin
        mst = '{0, 0};
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                mst[0] = 0;
                mst[1] = 0;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    case (mst[k])
                        0: if (mr) mst[k] = 1;
                        1: begin
                            mlen[k] = 0;
                            case (op)
                                7'b0000011: begin
                                    mseq[k][0] = 2; mseq[k][1] = 3;
                                    mseq[k][2] = 4; mlen[k] = 3;
                                end
                                7'b0100011: begin
                                    mseq[k][0] = 2; mseq[k][1] = 5; mlen[k] = 2;
                                end
                                7'b0110011: begin
                                    mseq[k][0] = 6; mseq[k][1] = 7; mlen[k] = 2;
                                end
                                7'b0010011: begin
                                    mseq[k][0] = 8; mseq[k][1] = 7; mlen[k] = 2;
                                end
                                7'b1101111: begin
                                    mseq[k][0] = 9; mseq[k][1] = 7; mlen[k] = 2;
                                end
                                7'b1100011: begin
                                    mseq[k][0] = 10; mlen[k] = 1;
                                end
                                default: if (halt_p[k]) begin
                                    mseq[k][0] = 11; mlen[k] = 1;
                                end
                            endcase
                            mst[k] = (mlen[k] == 0) ? 0 : mseq[k][0];
                            midx[k] = 1;
                        end
                        11: ;
                        default: begin
                            if ((mst[k] == 3 || mst[k] == 5) && !mr) ;
                            else if (midx[k] < mlen[k]) begin
                                mst[k] = mseq[k][midx[k]];
                                midx[k]++;
                            end else mst[k] = 0;
                        end
                    endcase
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            for (int k = 0; k < 2; k++) begin
                logic [21:0] e, m, a;
                e = expv(mst[k], op, funct3, funct7b5, Zero, mr, m);
                a = actv(k);
                vectors++;
                if (((a ^ e) & m) != 0) begin
                    fails++;
                    $display("FAIL cycle dut%0d t=%0t: got %h want %h mask %h",
                             k, $time, a, e, m);
                end
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s t=%0t: got %0h want %0h", nm, $time, a, e);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
    endtask

    task automatic rst_check();
        for (int k = 0; k < 2; k++) begin
            lit("rst_state", 32'(st[k]), 32'd0);
            lit("rst_en", {26'd0, pcw[k], irw[k], rw[k], mw[k], dn[k], il[k]},
                32'd0);
        end
    endtask

    // Assert reset mid-cycle, check the asynchronous effect, then release
    task automatic mid_reset();
        #2 reset_n = 1'b0;
        #1 rst_check();
        @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        #3 rst_check();
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;

        // lw: 0,1,2,3,4,0
        op = 7'b0000011; funct3 = 3'b010;
        lit("lw_s0", 32'(st[0]), 0);
        cyc(); lit("lw_s1", 32'(st[0]), 1);
        cyc(); lit("lw_s2", 32'(st[0]), 2);
        cyc(); lit("lw_s3", 32'(st[0]), 3);
        lit("lw_adr", 32'(adr[0]), 1);
        cyc(); lit("lw_s4", 32'(st[0]), 4);
        lit("lw_wb", {29'd0, rw[0], rs[0]}, 32'b101);
        cyc(); lit("lw_s5", 32'(st[0]), 0);

        // sub then addi with Instr[30]=1
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
        cyc(); cyc(); lit("sub_st", 32'(st[0]), 6);
        lit("sub_alu", 32'(al[0]), 32'b110);
        cyc(); cyc();
        op = 7'b0010011;
        cyc(); cyc(); lit("addi_st", 32'(st[0]), 8);
        lit("addi_alu", 32'(al[0]), 32'b010);
        cyc(); cyc();

        // beq taken then not taken
        op = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b1;
        cyc(); cyc(); lit("beq_t_st", 32'(st[0]), 10);
        lit("beq_t_pcw", 32'(pcw[0]), 1);
        cyc(); lit("beq_t_ret", 32'(st[0]), 0);
        Zero = 1'b0;
        cyc(); cyc(); lit("beq_n_pcw", 32'(pcw[0]), 0);
        cyc(); lit("beq_n_ret", 32'(st[0]), 0);

        // jal: 0,1,9,7,0
        op = 7'b1101111;
        #1 lit("jal_imm", 32'(im[0]), 3);
        cyc(); lit("jal_s1", 32'(st[0]), 1);
        cyc(); lit("jal_s9", 32'(st[0]), 9);
        lit("jal_pcw", 32'(pcw[0]), 1);
        cyc(); lit("jal_s7", 32'(st[0]), 7);
        lit("jal_rw", 32'(rw[0]), 1);
        cyc(); lit("jal_s0", 32'(st[0]), 0);

        // sw aborted by reset inside MEMWRITE
        op = 7'b0100011;
        cyc(); cyc(); cyc();
        lit("sw_st", 32'(st[0]), 5);
        lit("sw_mw", 32'(mw[0]), 1);
        mid_reset();

        // illegal opcode: dut halts, dut0 skips
        op = 7'b1110011;
        cyc(); lit("ill_dec", {30'd0, il}, 32'b11);
        cyc(); lit("ill_halt", 32'(st[0]), 11);
        lit("ill_skip", 32'(st[1]), 0);
        for (int i = 0; i < 20; i++) begin
            cyc();
            lit("halt_ill", {27'd0, il[0], st[0]}, {27'd0, 1'b1, 4'd11});
        end
        @(posedge clk);
        @(negedge clk);
        mid_reset();

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            Zero = 1'($urandom);
`ifdef MCTRL_MEMWAIT_EN
            mr = ($urandom_range(0, 3) != 0);
`endif
            if ((mst[0] == 0 || mst[0] == 11) && (mst[1] == 0 || mst[1] == 11)) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 6) begin
                    op = 7'($urandom);
                    if (legal(op)) op = 7'b1110011;
                end else begin
                    case ($urandom_range(0, 5))
                        0: op = 7'b0000011;
                        1: op = 7'b0100011;
                        2: op = 7'b0110011;
                        3: op = 7'b0010011;
                        4: op = 7'b1101111;
                        default: op = 7'b1100011;
                    endcase
                end
                funct3 = 3'($urandom);
                funct7b5 = 1'($urandom);
            end
            @(negedge clk);
            if ($urandom_range(0, 59) == 0 || (mst[0] == 11 && $urandom_range(0, 9) == 0))
                mid_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
